// File: rtl/regfile_pkg.sv
// Shared register-file definitions: geometry, dump FSM states and the word type.
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND0,
        SEND1,
        FIN
    } dumpState_t;

    typedef logic [DATA_W-1:0] rf_word_t;

endpackage

// File: rtl/rf_pair_buffer.sv
// Two-word snapshot of one register-file access (both read ports) plus the
// flag saying whether the second word belongs to the dump.
module rf_pair_buffer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic              pairIn,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    output logic [DATA_W-1:0] buf0,
    output logic [DATA_W-1:0] buf1,
    output logic              pair
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            buf0 <= '0;
            buf1 <= '0;
            pair <= 1'b0;
        end else if (capture) begin
            buf0 <= data1;
            buf1 <= data2;
            pair <= pairIn;
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks an inclusive register range, fetching two registers per access through
// the register file's read ports, and streams them out over valid/ready.
module regfile_dump_reader #(
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic              busy,
    output logic              done,
    output logic              range_err,
    output logic [ADDR_W-1:0] rf_readReg1,
    output logic [ADDR_W-1:0] rf_readReg2,
    input  logic [DATA_W-1:0] rf_readData1,
    input  logic [DATA_W-1:0] rf_readData2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    import regfile_pkg::*;

    dumpState_t        state, stateNext;
    // One extra bit so ptr+1 / ptr+2 past the top register never wraps to 0.
    logic [ADDR_W:0]   ptr, endPtr, ptrInc;
    logic              rangeErr;
    logic              hasPair;
    logic [ADDR_W-1:0] heldReg1, heldReg2, fetchReg2;
    logic [DATA_W-1:0] buf0, buf1;
    logic              bufPair;
    logic              capture;

    assign ptrInc    = ptr + 1'b1;
    assign hasPair   = ptr < endPtr;
    assign fetchReg2 = hasPair ? ptrInc[ADDR_W-1:0] : ptr[ADDR_W-1:0];
    assign capture   = (state == FETCH);

    // Read addresses are live only in FETCH; otherwise they park on the last fetch.
    assign rf_readReg1 = capture ? ptr[ADDR_W-1:0] : heldReg1;
    assign rf_readReg2 = capture ? fetchReg2 : heldReg2;

    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign range_err = done && rangeErr;

    rf_pair_buffer #(.DATA_W(DATA_W)) pairBuf (
        .clk     (clk),
        .reset   (reset),
        .capture (capture),
        .pairIn  (hasPair),
        .data1   (rf_readData1),
        .data2   (rf_readData2),
        .buf0    (buf0),
        .buf1    (buf1),
        .pair    (bufPair)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            endPtr   <= '0;
            rangeErr <= 1'b0;
            heldReg1 <= '0;
            heldReg2 <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE && start) begin
                ptr      <= {1'b0, first_reg};
                endPtr   <= {1'b0, last_reg};
                rangeErr <= (first_reg > last_reg);
            end
            if (state == FETCH) begin
                heldReg1 <= ptr[ADDR_W-1:0];
                heldReg2 <= fetchReg2;
            end
            if (state == SEND1 && out_ready && !out_last) begin
                ptr <= ptr + 2'd2;
            end
        end
    end

    always_comb begin
        stateNext = state;
        out_valid = 1'b0;
        out_addr  = '0;
        out_data  = '0;
        out_last  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    stateNext = (first_reg <= last_reg) ? FETCH : FIN;
                end
            end
            FETCH: stateNext = SEND0;
            SEND0: begin
                out_valid = 1'b1;
                out_addr  = ptr[ADDR_W-1:0];
                out_data  = buf0;
                out_last  = (ptr == endPtr);
                if (out_ready) begin
                    stateNext = (out_last || !bufPair) ? FIN : SEND1;
                end
            end
            SEND1: begin
                out_valid = 1'b1;
                out_addr  = ptrInc[ADDR_W-1:0];
                out_data  = buf1;
                out_last  = (ptrInc == endPtr);
                if (out_ready) begin
                    stateNext = out_last ? FIN : FETCH;
                end
            end
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader against a behavioural 32x32 register file.
module tb_regfile_dump_reader;

    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  first_reg, last_reg;
    logic        busy, done, range_err;
    logic [4:0]  rf_readReg1, rf_readReg2;
    logic [31:0] rf_readData1, rf_readData2;
    logic        out_valid, out_ready, out_last;
    logic [4:0]  out_addr;
    logic [31:0] out_data;

    rf_word_t rfMem [NUM_REGS];

    assign rf_readData1 = rfMem[rf_readReg1];
    assign rf_readData2 = rfMem[rf_readReg2];

    regfile_dump_reader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .first_reg    (first_reg),
        .last_reg     (last_reg),
        .busy         (busy),
        .done         (done),
        .range_err    (range_err),
        .rf_readReg1  (rf_readReg1),
        .rf_readReg2  (rf_readReg2),
        .rf_readData1 (rf_readData1),
        .rf_readData2 (rf_readData2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;

    logic [4:0]  gotAddr [$];
    logic [31:0] gotData [$];
    logic        gotLast [$];
    int doneCount, rangeErrCount, coincident, busyCycles, doneCycle;
    int firstValid, stallErr, zeroAccess;
    logic [4:0] fetchR1, fetchR2;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: out_ready held high; mode 1: out_ready 1,0,0 repeating from first valid cycle.
    task automatic runDump(input logic [4:0] f, input logic [4:0] l, input int mode);
        logic        prevValid, prevReady, prevLast;
        logic [4:0]  prevAddr;
        logic [31:0] prevData;
        gotAddr.delete();
        gotData.delete();
        gotLast.delete();
        doneCount = 0; rangeErrCount = 0; coincident = 0; busyCycles = 0;
        doneCycle = 0; firstValid = 0; stallErr = 0; zeroAccess = 0;
        prevValid = 1'b0; prevReady = 1'b0; prevLast = 1'b0;
        prevAddr = '0; prevData = '0;
        @(negedge clk);
        start = 1'b1; first_reg = f; last_reg = l; out_ready = 1'b1;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            out_ready = (mode == 0) ? 1'b1 : (((c - 2) % 3) == 0);
            if (c == 1) begin
                fetchR1 = rf_readReg1;
                fetchR2 = rf_readReg2;
            end
            if (busy) busyCycles++;
            if (busy && (rf_readReg1 == 5'd0 || rf_readReg2 == 5'd0)) zeroAccess++;
            if (done) begin
                doneCount++;
                doneCycle = c;
            end
            if (range_err) begin
                rangeErrCount++;
                if (done) coincident++;
            end
            if (out_valid && firstValid == 0) firstValid = c;
            if (prevValid && !prevReady &&
                (!out_valid || out_addr != prevAddr || out_data != prevData || out_last != prevLast))
                stallErr++;
            if (out_valid && out_ready) begin
                gotAddr.push_back(out_addr);
                gotData.push_back(out_data);
                gotLast.push_back(out_last);
            end
            prevValid = out_valid; prevReady = out_ready; prevLast = out_last;
            prevAddr = out_addr; prevData = out_data;
            if (doneCycle != 0 && c >= doneCycle + 2) break;
        end
    endtask

    task automatic checkWords(input string tag, input logic [4:0] f, input int n);
        checkVal({tag, "_count"}, gotAddr.size(), n);
        for (int i = 0; i < n && i < gotAddr.size(); i++) begin
            checkVal($sformatf("%s_addr%0d", tag, i), gotAddr[i], f + i);
            checkVal($sformatf("%s_data%0d", tag, i), gotData[i], rfMem[f + i]);
            checkVal($sformatf("%s_last%0d", tag, i), gotLast[i], (i == n - 1));
        end
    endtask

    initial begin
        int found;
        int sawDone;
        for (int i = 0; i < NUM_REGS; i++) rfMem[i] = 32'h1000_0000 + i;
        rfMem[1]  = 32'h12345678;
        rfMem[2]  = 32'h87654321;
        rfMem[3]  = 32'habcdefab;
        rfMem[4]  = 32'h8765abcd;
        rfMem[5]  = 32'ha1b2c3d4;
        rfMem[6]  = 32'he5f67a8b;
        rfMem[30] = 32'hdeadbeef;
        rfMem[31] = 32'hcafef00d;
        reset = 1'b0; start = 1'b0; first_reg = '0; last_reg = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkVal("rst_busy", busy, 0);
        checkVal("rst_done", done, 0);
        checkVal("rst_valid", out_valid, 0);
        checkVal("rst_rd1", rf_readReg1, 0);
        checkVal("rst_rd2", rf_readReg2, 0);
        checkVal("rst_data", out_data, 0);
        reset = 1'b1;

        runDump(5'd1, 5'd6, 0);
        checkWords("r1_6", 5'd1, 6);
        checkVal("r1_6_done", doneCount, 1);
        checkVal("r1_6_busy", busyCycles, 10);
        checkVal("r1_6_first_valid", firstValid, 2);
        checkVal("r1_6_done_cycle", doneCycle, 10);
        checkVal("r1_6_rangeerr", rangeErrCount, 0);

        runDump(5'd3, 5'd3, 0);
        checkWords("r3_3", 5'd3, 1);
        checkVal("r3_3_data_lit", gotData.size() > 0 ? gotData[0] : 32'h0, 32'habcdefab);
        checkVal("r3_3_fetch_rd1", fetchR1, 3);
        checkVal("r3_3_fetch_rd2", fetchR2, 3);
        checkVal("r3_3_done", doneCount, 1);
        checkVal("r3_3_hold_rd2", rf_readReg2, 3);

        runDump(5'd30, 5'd31, 0);
        checkWords("r30_31", 5'd30, 2);
        checkVal("r30_31_noreg0", zeroAccess, 0);
        checkVal("r30_31_fetch_rd2", fetchR2, 31);
        checkVal("r30_31_done", doneCount, 1);

        runDump(5'd5, 5'd2, 0);
        checkVal("empty_words", gotAddr.size(), 0);
        checkVal("empty_valid", firstValid, 0);
        checkVal("empty_done", doneCount, 1);
        checkVal("empty_rangeerr", rangeErrCount, 1);
        checkVal("empty_coincident", coincident, 1);
        checkVal("empty_done_cycle", doneCycle, 1);

        runDump(5'd1, 5'd4, 1);
        checkWords("stall", 5'd1, 4);
        checkVal("stall_stable", stallErr, 0);
        checkVal("stall_done", doneCount, 1);

        @(negedge clk);
        start = 1'b1; first_reg = 5'd1; last_reg = 5'd6; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 30 && found == 0; c++) begin
            if (out_valid && out_addr == 5'd2) found = 1;
            else @(negedge clk);
        end
        checkVal("abort_reach_send1", found, 1);
        reset = 1'b0;
        @(negedge clk);
        checkVal("abort_valid", out_valid, 0);
        checkVal("abort_busy", busy, 0);
        checkVal("abort_done", done, 0);
        reset = 1'b1;
        sawDone = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done || out_valid) sawDone++;
        end
        checkVal("abort_quiet", sawDone, 0);
        runDump(5'd1, 5'd6, 0);
        checkWords("after_abort", 5'd1, 6);
        checkVal("after_abort_done", doneCount, 1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Read-side master for the 32x32 register file: walks an inclusive register range and streams each register's contents out over a valid/ready interface.
- Drives the register file's two read ports (readReg1/readReg2) and fetches two registers per access.
- Used for debug dump, context save and bench self-checking.
- Sits beside the write path and never drives regWrite.

Parameters:
- ADDR_W, 5, register index width.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset. Sampled on the rising clk edge; 0 = reset.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- first_reg  in  ADDR_W  first register index, inclusive; latched on start.
- last_reg  in  ADDR_W  last register index, inclusive; latched on start.
- busy  out  1  high from the cycle after an accepted start until DONE completes.
- done  out  1  one-cycle pulse when the dump ends or the range is empty.
- range_err  out  1  one-cycle pulse, coincident with done, when first_reg > last_reg.
- rf_readReg1  out  ADDR_W  register file read address 1.
- rf_readReg2  out  ADDR_W  register file read address 2.
- rf_readData1  in  DATA_W  register file read data 1; combinational, same cycle as address.
- rf_readData2  in  DATA_W  register file read data 2; combinational, same cycle as address.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accepts the word.
- out_addr  out  ADDR_W  register index of out_data.
- out_data  out  DATA_W  register contents.
- out_last  out  1  marks the final word of the dump.

Behaviour:
- Reset (reset=0 at a clk edge):
  - State goes to IDLE.
  - busy, done, range_err, out_valid and out_last are 0.
  - out_addr, out_data, rf_readReg1 and rf_readReg2 are 0.
  - Reset mid-dump aborts at once: no further words and no done pulse.
- States: IDLE, FETCH, SEND0, SEND1, FIN.
- IDLE:
  - start=1 with first_reg<=last_reg: latch ptr=first_reg and end=last_reg, go to FETCH.
  - start=1 with first_reg>last_reg: go to FIN with range_err flagged; no words are emitted.
- FETCH (exactly 1 cycle):
  - rf_readReg1=ptr.
  - rf_readReg2 = ptr+1 if ptr<end, otherwise ptr. This avoids wrapping 31 to 0.
  - Capture rf_readData1 into buf0 and rf_readData2 into buf1.
  - pair = (ptr<end).
  - Go to SEND0.
- SEND0:
  - out_valid=1, out_addr=ptr, out_data=buf0, out_last=(ptr==end).
  - On out_valid&&out_ready: if out_last, go to FIN; else go to SEND1 (pair is guaranteed).
- SEND1:
  - out_valid=1, out_addr=ptr+1, out_data=buf1, out_last=(ptr+1==end).
  - On handshake: if out_last, go to FIN; else ptr+=2 and go to FETCH.
- FIN (1 cycle): done=1, range_err as flagged, busy=0 on exit; go to IDLE.
- Stream stability: while out_valid=1 and out_ready=0, out_addr, out_data and out_last hold constant. out_valid never drops without a handshake except on reset.
- Outside FETCH, rf_readReg1 and rf_readReg2 hold their last FETCH value.
- Snapshot rule: each value reflects the register file at its FETCH cycle. A write landing after that cycle is not seen for that pair.
- start is ignored while busy.
- Latency: start accepted at edge k; FETCH runs in cycle k+1; first out_valid is at cycle k+2.
- Throughput with out_ready held high: 2 words per 3 cycles.
- Range n..n (single register): 1 word with out_last=1; rf_readReg2=n.
- ptr arithmetic is ADDR_W+1 bits internally, so ptr+2 past 31 never wraps.

Decomposition:
- Shared package regfile_pkg holds:
  - ADDR_W=5, DATA_W=32, NUM_REGS=32.
  - The dump state enum (IDLE, FETCH, SEND0, SEND1, FIN).
  - The rf_word_t typedef.
- The two-entry pair buffer (buf0/buf1 plus pair flag) is a natural sub-module, rf_pair_buffer. Everything else stays in one FSM module.

Test Plan:
- Preload regs 1..6 with 12345678, 87654321, abcdefab, 8765abcd, a1b2c3d4, e5f67a8b; start first=1 last=6, out_ready=1 -> 6 words, addr 1..6 with matching data; out_last only on addr 6; done pulses once; busy high for 10 cycles.
- Same preload, first=3 last=3 -> single word addr 3, data abcdefab, out_last=1; rf_readReg2=3 during FETCH.
- first=30 last=31 with regs 30/31 = deadbeef/cafef00d -> 2 words; no access to reg 0; out_last on addr 31.
- first=5 last=2 -> no out_valid; done=1 and range_err=1 in the same cycle, 1 cycle after start.
- Range 1..4 with out_ready toggled 1,0,0,1,... -> data and addr held stable across stalls; order and values unchanged.
- Assert reset=0 while in SEND1 of range 1..6 -> next cycle out_valid=0 and busy=0; no done pulse; a subsequent start runs normally from first_reg.
